mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: DEPTH x 32 synchronous RAM behind the MAR/MDR pair, fronted by a
// multi-cycle controller (IDLE -> WAIT -> ACCESS -> DONE).
//
// Handshake (4-phase level protocol):
//   The requester raises exactly one of Read/Write and holds it. The controller
//   captures MARout/MDRout/op on the first edge it sees the request in IDLE.
//   After WAIT_CYCLES wait states and one ACCESS cycle it raises MemDone.
//   MemDone stays high until the requester drops its request. The controller
//   returns to IDLE on the first edge where Read and Write are both low, so
//   MemDone falls one cycle after the release. Inputs are ignored between
//   capture and the return to IDLE.
//   If Read and Write are both high in IDLE, nothing is captured and MemErr
//   pulses for that cycle. An out-of-range address is accepted and completes
//   with normal timing, but the access is suppressed (a read returns 0). In
//   that case MemErr pulses once, on the cycle after the capture edge.
module mem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] MARout,
    input  logic [31:0] MDRout,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        MemDone,
    output logic        Busy,
    output logic        MemErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_32  = 32'(DEPTH);

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                op_q;     // 1 = write, 0 = read
    logic                oor_q;    // captured address was out of range

    logic [31:0]         mem [DEPTH];

    logic                req_one;
    logic                req_both;
    logic                out_of_range;

    // Request decode. Comparing the full 32-bit MAR against DEPTH also catches
    // any nonzero bits above ADDR_W, because DEPTH never exceeds 2^ADDR_W.
    assign req_one      = Read ^ Write;
    assign req_both     = Read & Write;
    assign out_of_range = (MARout >= DEPTH_32);

    // Controller FSM with registered handshake outputs and read data.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= 1'b0;
            oor_q   <= 1'b0;
            Mdatain <= '0;
            MemDone <= 1'b0;
            Busy    <= 1'b0;
            MemErr  <= 1'b0;
        end else begin
            MemErr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_both) begin
                        MemErr <= 1'b1;
                    end else if (req_one) begin
                        addr_q <= MARout[ADDR_W-1:0];
                        data_q <= MDRout;
                        op_q   <= Write;
                        oor_q  <= out_of_range;
                        MemErr <= out_of_range;
                        Busy   <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACCESS;
                            cnt   <= '0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!op_q) begin
                        Mdatain <= oor_q ? 32'd0 : mem[addr_q];
                    end
                    state   <= S_DONE;
                    MemDone <= 1'b1;
                end
                S_DONE: begin
                    if (!(Read | Write)) begin
                        state   <= S_IDLE;
                        MemDone <= 1'b0;
                        Busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM write port: no reset on contents. A write that clr interrupts never
    // reaches this port, because clr blocks the ACCESS-cycle write.
    always_ff @(posedge clk) begin
        if (!clr && state == S_ACCESS && op_q && !oor_q) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: three mem_ctrl instances (WAIT_CYCLES = 1, 0, 3) share clk,
// clr, MARout and MDRout. Each instance has its own Read/Write lines.
// Read expectations are queued when a read is issued. They are popped and
// compared when MemDone rises.
module tb_mem_ctrl;

    localparam int N = 3;
    localparam int WC [N] = '{1, 0, 3};

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   mar = '0;
    logic [31:0]   mdr = '0;
    logic [N-1:0]  rd  = '0;
    logic [N-1:0]  wr  = '0;
    logic [31:0]   dout [N];
    logic [N-1:0]  done;
    logic [N-1:0]  busy;
    logic [N-1:0]  err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [N][512];
    logic [31:0] last_rd [N];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_ctrl #(
            .ADDR_W     (9),
            .DEPTH      (512),
            .WAIT_CYCLES(WC[g])
        ) u_dut (
            .clk    (clk),
            .clr    (clr),
            .MARout (mar),
            .MDRout (mdr),
            .Read   (rd[g]),
            .Write  (wr[g]),
            .Mdatain(dout[g]),
            .MemDone(done[g]),
            .Busy   (busy[g]),
            .MemErr (err[g])
        );
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_done"}, 32'(done[i]), 32'd0);
            check({tag, "_busy"}, 32'(busy[i]), 32'd0);
            check({tag, "_err"},  32'(err[i]),  32'd0);
            check({tag, "_dout"}, dout[i],      32'd0);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one full handshake on instance d.
    // hold = extra cycles the request stays high after MemDone rises.
    task automatic access(input int d, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] data, input int hold);
        bit          oor;
        bit          seen;
        int          cyc;
        logic [31:0] a9;
        oor  = (addr >= 32'd512);
        a9   = addr & 32'h1ff;
        seen = 1'b0;
        cyc  = 0;
        mar  = addr;
        mdr  = data;
        if (is_wr) begin
            wr[d] = 1'b1;
        end else begin
            rd[d] = 1'b1;
            exp_q.push_back(oor ? 32'd0 : model[d][a9]);
        end
        while (cyc < 40) begin
            step();
            cyc++;
            check("memerr", 32'(err[d]), 32'((cyc == 1) && oor));
            if (done[d]) begin
                seen = 1'b1;
                break;
            end
            check("busy_during", 32'(busy[d]), 32'd1);
        end
        if (!seen) begin
            check("timeout_memdone", 32'd0, 32'd1);
        end else begin
            // The capture edge is the first edge after the drive, so the
            // count includes that edge plus WAIT_CYCLES + 1 edges.
            check("latency", 32'(cyc), 32'(WC[d] + 2));
            check("busy_done", 32'(busy[d]), 32'd1);
            if (!is_wr) begin
                check("rdata", dout[d], exp_q.pop_front());
                last_rd[d] = oor ? 32'd0 : model[d][a9];
            end else begin
                check("dout_kept", dout[d], last_rd[d]);
                if (!oor) model[d][a9] = data;
            end
        end
        for (int h = 0; h < hold; h++) begin
            step();
            check("done_hold", 32'(done[d]), 32'd1);
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        step();
        check("done_drop", 32'(done[d]), 32'd0);
        check("busy_drop", 32'(busy[d]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) last_rd[i] = '0;

        // Power-on reset
        clr = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        check_idle_outputs("reset");

        // Write/read with W=1, with MemDone held for 2 extra cycles
        access(0, 1'b1, 32'h20, 32'h1234_5678, 2);
        access(0, 1'b0, 32'h20, 32'h0, 1);

        // Reset mid-WAIT of a write: the write must not land
        access(0, 1'b1, 32'h5, 32'h0, 0);
        mar   = 32'h5;
        mdr   = 32'hDEAD_BEEF;
        wr[0] = 1'b1;
        step();
        check("rst_busy_pre", 32'(busy[0]), 32'd1);
        clr = 1'b1;
        repeat (2) step();
        check_idle_outputs("midreset");
        wr[0] = 1'b0;
        clr   = 1'b0;
        for (int i = 0; i < N; i++) last_rd[i] = '0;
        step();
        check("post_rst_done", 32'(done[0]), 32'd0);
        access(0, 1'b0, 32'h5, 32'h0, 0);

        // Read/Write conflict held for 3 cycles
        mar   = 32'h20;
        mdr   = 32'hFFFF_FFFF;
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("conflict_err", 32'(err[0]), 32'd1);
            check("conflict_busy", 32'(busy[0]), 32'd0);
        end
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        step();
        check("conflict_err_end", 32'(err[0]), 32'd0);
        access(0, 1'b0, 32'h20, 32'h0, 0);

        // Out-of-range accesses
        access(0, 1'b1, 32'h0, 32'h0F0F_0F0F, 0);
        access(0, 1'b1, 32'h200, 32'hAAAA_5555, 0);
        access(0, 1'b0, 32'h0, 32'h0, 0);
        access(0, 1'b0, 32'h8000_0001, 32'h0, 0);

        // Back-to-back reads, each released as soon as MemDone rises
        access(0, 1'b1, 32'h1, 32'h11, 0);
        access(0, 1'b1, 32'h2, 32'h22, 0);
        access(0, 1'b1, 32'h3, 32'h33, 0);
        access(0, 1'b0, 32'h1, 32'h0, 0);
        access(0, 1'b0, 32'h2, 32'h0, 0);
        access(0, 1'b0, 32'h3, 32'h0, 0);

        // W=0 and W=3 instances: latency and busy window
        for (int d = 1; d < N; d++) begin
            access(d, 1'b1, 32'h40 + 32'(d), 32'hC0DE_0000 + 32'(d), 1);
            access(d, 1'b0, 32'h40 + 32'(d), 32'h0, 0);
            access(d, 1'b0, 32'h1FF + 32'(d), 32'h0, 0);
        end

        // Random write/readback on all instances
        for (int k = 0; k < 8; k++) begin
            int          d;
            logic [31:0] a;
            d = $urandom_range(0, N - 1);
            a = 32'($urandom_range(0, 511));
            access(d, 1'b1, a, $urandom, $urandom_range(0, 2));
            access(d, 1'b0, a, 32'h0, $urandom_range(0, 2));
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
